// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides:
// FSM state encoding, default frame width, parity type constants and a
// small helper that sanitises the bit-period setting.
package uart_pkg;

  // Default number of data bits per frame.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Parity type selector values for PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Shortest bit period the timer is allowed to run with.
  localparam logic [5:0] MIN_PRESCALE = 6'd4;

  // Frame state encoding shared by TX and RX.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Very short bit periods are stretched to the minimum; everything else is
  // used exactly as given.
  function automatic logic [5:0] clamp_prescale(input logic [5:0] p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit serializer: holds the frame's data word, presents the bit that
// goes on the line next at ser_bit, and counts which data bit is on the line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  output logic                  ser_bit,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;

  // Load the word on acceptance, shift LSB-first as bits are handed out and
  // count data bits 0..DATA_WIDTH-1 without ever wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        shreg <= shreg >> 1;
      end
      if (cnt_en && (bit_cnt != LAST_IDX)) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // The low bit of the shift register is always the next data bit to send.
  always_comb begin
    ser_bit  = shreg[0];
    last_bit = (bit_cnt == LAST_IDX);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. One frame = start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit; each bit lasts Prescale CLK cycles.
//
// Request handshake: DATA_VALID is a request strobe. It is accepted on a
// CLK edge only while the FSM is in IDLE (Busy low); at that edge P_DATA,
// PAR_EN, PAR_TYP and Prescale are captured. Requests made while Busy is
// high are dropped, never queued. Busy is the only "not ready" indication.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy,
  output tx_state_e             dbg_state
);

  tx_state_e  state;
  logic [5:0] bit_tmr;
  logic [5:0] presc_q;
  logic       par_en_q;
  logic       par_bit_q;

  logic       accept;
  logic       bit_end;
  logic       shift_en;
  logic       cnt_en;
  logic       ser_bit;
  logic       ser_last;

  // Acceptance and bit-boundary strobes that steer the serializer.
  always_comb begin
    accept   = (state == IDLE) && DATA_VALID;
    bit_end  = (state != IDLE) && (bit_tmr == (presc_q - 6'd1));
    shift_en = bit_end && ((state == START) || ((state == DATA) && !ser_last));
    cnt_en   = bit_end && (state == DATA) && !ser_last;
  end

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .load_data (P_DATA),
    .shift_en  (shift_en),
    .cnt_en    (cnt_en),
    .ser_bit   (ser_bit),
    .last_bit  (ser_last)
  );

  // Frame FSM with bit timer; TX_OUT and Busy are registered so the line
  // value for the next bit is decided at the edge that ends the current one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      bit_tmr   <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          bit_tmr <= '0;
          if (DATA_VALID) begin
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            presc_q   <= clamp_prescale(Prescale);
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
          end
        end

        START: begin
          if (bit_end) begin
            bit_tmr <= '0;
            state   <= DATA;
            TX_OUT  <= ser_bit;
          end else begin
            bit_tmr <= bit_tmr + 6'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_tmr <= '0;
            if (!ser_last) begin
              TX_OUT <= ser_bit;
            end else if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            bit_tmr <= bit_tmr + 6'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            bit_tmr <= '0;
            state   <= STOP;
            TX_OUT  <= 1'b1;
          end else begin
            bit_tmr <= bit_tmr + 6'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_tmr <= '0;
            state   <= IDLE;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
          end else begin
            bit_tmr <= bit_tmr + 6'd1;
          end
        end

        default: begin
          state   <= IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          bit_tmr <= '0;
        end
      endcase
    end
  end

  // State visibility for checkers.
  always_comb begin
    dbg_state = state;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  oversampling clock; bit period = Prescale CLK cycles.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to send.
REQ-005 SHALL have port DATA_VALID  input  1  send request, one CLK cycle is sufficient.
REQ-006 SHALL have port PAR_EN  input  1  1 = parity bit inserted after data.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port Prescale  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have port Busy  output  1  frame in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a request when DATA_VALID=1 in IDLE, and only then.
REQ-013 SHALL latch P_DATA, PAR_EN, PAR_TYP and Prescale on the accepting edge; input changes during a frame SHALL NOT affect that frame.
REQ-014 SHALL ignore DATA_VALID outside IDLE, with no queuing.
REQ-015 SHALL drive TX_OUT=0 (START) from the cycle after acceptance, for exactly Prescale cycles.
REQ-016 SHALL send DATA_WIDTH data bits LSB first, each held for Prescale cycles.
REQ-017 SHALL, if latched PAR_EN=1, send one parity bit: even = XOR of data bits; odd = its inverse; PARITY state skipped when PAR_EN=0.
REQ-018 SHALL send one stop bit (TX_OUT=1) for Prescale cycles, then return to IDLE.
REQ-019 SHALL treat a latched Prescale below 4 as 4; other values SHALL be used as given.
REQ-020 SHALL register TX_OUT (no combinational path from inputs).
REQ-021 SHALL hold TX_OUT=1 in IDLE.
REQ-022 SHALL assert Busy from the first START cycle through the last STOP cycle, and deassert it in IDLE.
REQ-023 SHALL leave at least one IDLE cycle between frames; DATA_VALID held high SHALL start the next frame after exactly one idle-high cycle.
REQ-024 SHALL give frame length (1+DATA_WIDTH+PAR_EN+1)*Prescale cycles of Busy.
REQ-025 SHALL run a bit-period counter from 0 to Prescale-1 and a bit counter from 0 to DATA_WIDTH-1, with no wrap beyond those limits.

Reset
REQ-026 SHALL, on RST low, asynchronously force: FSM IDLE, TX_OUT=1, Busy=0, all counters and latched registers 0.
REQ-027 SHALL abort any frame in progress when reset occurs mid-frame; no partial frame SHALL resume after release.
REQ-028 SHALL accept DATA_VALID on the first CLK edge after RST deasserts.

Structure
REQ-029 SHALL take the FSM state encoding, default DATA_WIDTH and PAR_TYP constants (EVEN=0, ODD=1) from shared package uart_pkg, which the RX side also uses.
REQ-030 SHALL place the shift register and data-bit counter in sub-module uart_tx_serializer; the FSM, bit timer and parity SHALL be in the top level.

Verification
REQ-031 SHALL cover: Prescale=8, PAR_EN=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; Busy high 80 cycles.
REQ-032 SHALL cover: Prescale=16, PAR_EN=1, P_DATA=0x07 -> parity bit 1 when PAR_TYP=0 and 0 when PAR_TYP=1; Busy high 176 cycles.
REQ-033 SHALL cover: DATA_VALID pulsed with P_DATA=0xFF and Prescale=32 during the DATA state -> current frame unchanged, no second frame.
REQ-034 SHALL cover: DATA_VALID held high, P_DATA=0x55 then 0x0F -> two complete frames; second start bit begins exactly 1 cycle after first stop bit ends.
REQ-035 SHALL cover: RST low during data bit 3 -> TX_OUT=1 and Busy=0 immediately; after release, DATA_VALID with 0x3C -> clean full frame.
REQ-036 SHALL cover: PAR_EN=0, Prescale=2 -> each bit lasts 4 cycles; Busy high 40 cycles.
